cdb_arb: RTL

//  Parametrised common-data-bus arbiter: NUM_SRC execution units (ALU/MDU/LSU/...) request one

---
 rtl/cdb_pkg.sv | 20 ++
 rtl/cdb_rr_pick.sv | 31 +++
 rtl/cdb_arb.sv | 81 ++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
// Shared CDB types and source-index constants for the common-data-bus arbiter.
// The cdb_bus_t field widths set the beat width; cdb_arb's TAG_W/DATA_W must match them.
package cdb_pkg;

  localparam int CDB_NUM_SRC = 3;
  localparam int CDB_TAG_W   = 4;
  localparam int CDB_DATA_W  = 32;
  localparam int SRC_IDX_W   = $clog2(CDB_NUM_SRC);

  localparam logic [SRC_IDX_W-1:0] SRC_MDU = SRC_IDX_W'(0);
  localparam logic [SRC_IDX_W-1:0] SRC_LSU = SRC_IDX_W'(1);
  localparam logic [SRC_IDX_W-1:0] SRC_ALU = SRC_IDX_W'(2);

  typedef struct packed {
    logic                  wr;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] wdata;
  } cdb_bus_t;

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational priority picker: first set req bit searching upward from start, wrapping
// modulo N (N need not be a power of two).
module cdb_rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int i;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    i   = 0;
    for (int off = 0; off < N; off++) begin
      i = int'(start) + off;
      if (i >= N) i = i - N;
      if (!any && req[i]) begin
        any    = 1'b1;
        gnt[i] = 1'b1;
        idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/cdb_arb.sv
// Common-data-bus arbiter: one registered result beat per cycle from NUM_SRC units.
// Fixed priority (unit 0 first) by default; define CDB_RR_EN for round-robin fairness.
module cdb_arb
  import cdb_pkg::*;
#(
  parameter int NUM_SRC = CDB_NUM_SRC,
  parameter int TAG_W   = CDB_TAG_W,
  parameter int DATA_W  = CDB_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_SRC-1:0]         src_req,
  input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
  input  logic [NUM_SRC*DATA_W-1:0]  src_wdata,
  output logic [NUM_SRC-1:0]         src_rdy,
  output logic                       cdb_wr,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_wdata,
  output logic [$clog2(NUM_SRC)-1:0] cdb_src
);

  localparam int IW = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] gnt;
  logic [IW-1:0]      idx;
  logic               any;
  logic [IW-1:0]      start;
  logic               grant;
  cdb_bus_t           beat_q;
  logic [IW-1:0]      src_q;

`ifdef CDB_RR_EN
  logic [IW-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (grant)
      ptr <= (idx == IW'(NUM_SRC-1)) ? '0 : idx + 1'b1;
  end

  assign start = ptr;
`else
  assign start = '0;
`endif

  cdb_rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
    .req   (src_req),
    .start (start),
    .gnt   (gnt),
    .idx   (idx),
    .any   (any)
  );

  // Flush suppresses the grant so the unit keeps its result and the pointer holds.
  assign grant   = any & ~flush;
  assign src_rdy = flush ? '0 : gnt;

  // Idle beats are zeroed so a stale tag can never match a waiting consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q <= '0;
      src_q  <= '0;
    end else if (grant) begin
      beat_q.wr    <= 1'b1;
      beat_q.tag   <= src_tag[idx*TAG_W +: TAG_W];
      beat_q.wdata <= src_wdata[idx*DATA_W +: DATA_W];
      src_q        <= idx;
    end else begin
      beat_q <= '0;
      src_q  <= '0;
    end
  end

  assign cdb_wr    = beat_q.wr;
  assign cdb_tag   = beat_q.tag;
  assign cdb_wdata = beat_q.wdata;
  assign cdb_src   = src_q;

endmodule
